// File: rtl/w_prefetch_ctrl.sv
// Multi-bank weight prefetch controller: fills NBANK weight banks ahead of compute and
// hands full banks to the array. Optional perf counters enabled by WPF_PERF_CNT_EN.
module w_prefetch_ctrl #(
  parameter int ROWS   = 8,
  parameter int NBANK  = 2,
  parameter int TILE_W = 16,
  parameter int RW     = $clog2(ROWS),
  parameter int BW     = $clog2(NBANK)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [TILE_W-1:0] num_tiles,
  output logic              w_read,
  input  logic              w_gnt,
  output logic [RW-1:0]     w_row,
  output logic [BW-1:0]     w_bank,
  output logic              clr_w,
  input  logic              if_ready,
  input  logic              comp_done,
  output logic              switch,
  output logic [BW-1:0]     act_bank,
  output logic              start_if,
  output logic              ready,
  output logic              done
`ifdef WPF_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       fill_cycles
`endif
);

  localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
  localparam logic [BW-1:0] LAST_BANK = BW'(NBANK - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t            state;
  logic [TILE_W-1:0] tiles_total;
  logic [TILE_W-1:0] tiles_fetched;
  logic [TILE_W-1:0] tiles_launched;
  logic [TILE_W-1:0] tiles_done;
  logic [BW-1:0]     wr_bank;
  logic [BW-1:0]     rd_bank;
  logic [NBANK-1:0]  full;
  logic              comp_active;

  logic fill_go;
  logic launch_go;
  logic fill_last;

  // A bank owned by an active compute pass must not be overwritten.
  assign fill_go   = (state == S_RUN) && !w_read && (tiles_fetched < tiles_total) &&
                     !full[wr_bank] && !(comp_active && (wr_bank == act_bank));
  assign launch_go = (state == S_RUN) && full[rd_bank] && !comp_active && if_ready;
  assign fill_last = w_read && w_gnt && (w_row == LAST_ROW);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      tiles_total    <= '0;
      tiles_fetched  <= '0;
      tiles_launched <= '0;
      tiles_done     <= '0;
      wr_bank        <= '0;
      rd_bank        <= '0;
      full           <= '0;
      comp_active    <= 1'b0;
      w_read         <= 1'b0;
      w_row          <= '0;
      w_bank         <= '0;
      clr_w          <= 1'b0;
      switch         <= 1'b0;
      act_bank       <= '0;
      start_if       <= 1'b0;
      ready          <= 1'b1;
      done           <= 1'b0;
    end else begin
      clr_w    <= 1'b0;
      switch   <= 1'b0;
      done     <= 1'b0;
      start_if <= switch;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (num_tiles != '0) begin
              tiles_total    <= num_tiles;
              tiles_fetched  <= '0;
              tiles_launched <= '0;
              tiles_done     <= '0;
              wr_bank        <= '0;
              rd_bank        <= '0;
              full           <= '0;
              ready          <= 1'b0;
              state          <= S_RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (fill_go) begin
            clr_w  <= 1'b1;
            w_read <= 1'b1;
            w_row  <= '0;
            w_bank <= wr_bank;
          end
          // Grant gaps only stall the row index; the request stays up for the whole tile.
          if (w_read && w_gnt) begin
            if (fill_last) begin
              w_read        <= 1'b0;
              w_row         <= '0;
              full[wr_bank] <= 1'b1;
              wr_bank       <= (wr_bank == LAST_BANK) ? '0 : wr_bank + 1'b1;
              tiles_fetched <= tiles_fetched + 1'b1;
            end else begin
              w_row <= w_row + 1'b1;
            end
          end
          if (launch_go) begin
            switch         <= 1'b1;
            act_bank       <= rd_bank;
            full[rd_bank]  <= 1'b0;
            comp_active    <= 1'b1;
            rd_bank        <= (rd_bank == LAST_BANK) ? '0 : rd_bank + 1'b1;
            tiles_launched <= tiles_launched + 1'b1;
          end
          if (comp_done && comp_active) begin
            comp_active <= 1'b0;
            tiles_done  <= tiles_done + 1'b1;
          end
          if (tiles_done == tiles_total) begin
            done  <= 1'b1;
            ready <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef WPF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      fill_cycles  <= '0;
    end else if ((state == S_IDLE) && start) begin
      stall_cycles <= '0;
      fill_cycles  <= '0;
    end else begin
      if ((state == S_RUN) && if_ready && !comp_active && !full[rd_bank] &&
          (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
      if (w_read && (fill_cycles != '1))
        fill_cycles <= fill_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_w_prefetch_ctrl.sv
// Scoreboard bench for w_prefetch_ctrl (ROWS=4, NBANK=2): stimulus queues expected
// row transfers, bank switches and done pulses; a negedge monitor pops and compares.
module tb_w_prefetch_ctrl;
  localparam int ROWS = 4, NBANK = 2, TILE_W = 16;
  localparam int RW = $clog2(ROWS), BW = $clog2(NBANK);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [TILE_W-1:0] num_tiles = '0;
  logic              w_read;
  logic              w_gnt = 1'b1;
  logic [RW-1:0]     w_row;
  logic [BW-1:0]     w_bank;
  logic              clr_w;
  logic              if_ready = 1'b1;
  logic              comp_done = 1'b0;
  logic              switch;
  logic [BW-1:0]     act_bank;
  logic              start_if;
  logic              ready;
  logic              done;
`ifdef WPF_PERF_CNT_EN
  logic [31:0]       stall_cycles;
  logic [31:0]       fill_cycles;
  int                stall_at_sw = 0;
`endif

  w_prefetch_ctrl #(.ROWS(ROWS), .NBANK(NBANK), .TILE_W(TILE_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles),
    .w_read(w_read), .w_gnt(w_gnt), .w_row(w_row), .w_bank(w_bank), .clr_w(clr_w),
    .if_ready(if_ready), .comp_done(comp_done), .switch(switch), .act_bank(act_bank),
    .start_if(start_if), .ready(ready), .done(done)
`ifdef WPF_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .fill_cycles(fill_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  int exp_xfer[$];
  int exp_sw[$];
  int exp_done[$];
  int clr_q[$];
  int sw_cnt = 0, si_cnt = 0, done_cnt = 0;
  int last_sw = 0, last_si = 0, last_done = 0;
  int comp_delay = 5, cd = 0;
  bit busy = 0, overlap = 0, gnt_toggle = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tile t lands in bank t%2 (banks restart at 0 for every job).
  task automatic push_job(input int n);
    for (int t = 0; t < n; t++) begin
      for (int r = 0; r < ROWS; r++) exp_xfer.push_back((t % 2) * 16 + r);
      exp_sw.push_back(t % 2);
    end
    exp_done.push_back(1);
  endtask

  task automatic start_job(input int n, output int c0);
    clr_q.delete();
    start = 1'b1;
    num_tiles = TILE_W'(n);
    tick();
    start = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt == d0) chk("done_timeout", 0, 1);
    tick();
    chk("xfer_left", 32'(exp_xfer.size()), 0);
    chk("switch_left", 32'(exp_sw.size()), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_w_read"}, 32'(w_read), 0);
    chk({tag, "_w_row"}, 32'(w_row), 0);
    chk({tag, "_w_bank"}, 32'(w_bank), 0);
    chk({tag, "_clr_w"}, 32'(clr_w), 0);
    chk({tag, "_switch"}, 32'(switch), 0);
    chk({tag, "_act_bank"}, 32'(act_bank), 0);
    chk({tag, "_start_if"}, 32'(start_if), 0);
    chk({tag, "_ready"}, 32'(ready), 1);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  // Grant source: constant 1, or 1,0,1,0 phased so each tile's first cycle is granted.
  initial forever begin
    tick();
    if (gnt_toggle) w_gnt = clr_w ? 1'b1 : ~w_gnt;
    else w_gnt = 1'b1;
  end

  // Compute side model: comp_done comp_delay cycles after each start_if.
  initial forever begin
    tick();
    comp_done = 1'b0;
    if (rst) begin
      cd = 0;
      busy = 0;
    end else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          comp_done = 1'b1;
          busy = 0;
        end
      end
      if (start_if) begin
        cd = comp_delay;
        busy = 1;
      end
    end
  end

  // Monitor
  initial begin
    bit prev_sw = 0, prev_wread = 0, prev_gnt = 0;
    int prev_row = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_sw = 0;
        prev_wread = 0;
      end else begin
        if (w_read && w_gnt) begin
          if (exp_xfer.size() == 0) chk("xfer_unexpected", 32'(w_bank * 16 + w_row), 99);
          else chk("xfer_bank_row", 32'(w_bank * 16 + w_row), exp_xfer.pop_front());
        end
        if (clr_w) begin
          chk("clr_w_row0", 32'(w_row), 0);
          chk("clr_w_read", 32'(w_read), 1);
          clr_q.push_back(cyc);
        end
        if (prev_wread && !w_read) chk("w_read_drop_at_last_row", 32'(prev_gnt * 16 + prev_row), 16 + ROWS - 1);
        if (switch) begin
          if (exp_sw.size() == 0) chk("switch_unexpected", 32'(act_bank), 99);
          else chk("switch_act_bank", 32'(act_bank), exp_sw.pop_front());
          sw_cnt++;
          last_sw = cyc;
`ifdef WPF_PERF_CNT_EN
          if (sw_cnt == 1) stall_at_sw = int'(stall_cycles);
`endif
        end
        if (start_if || prev_sw) chk("start_if_after_switch", 32'(start_if), 32'(prev_sw));
        if (start_if) begin
          si_cnt++;
          last_si = cyc;
        end
        if (done) begin
          if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
          else begin
            void'(exp_done.pop_front());
            chk("done_with_ready", 32'(ready), 1);
          end
          done_cnt++;
          last_done = cyc;
        end
        if (w_read && busy && w_bank != act_bank) overlap = 1;
        prev_sw = switch;
        prev_wread = w_read;
        prev_gnt = w_gnt;
        prev_row = int'(w_row);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, s0, d0, n;
    repeat (3) tick();
    chk_reset_vals("reset");
    rst = 1'b0;
    tick();

    // Single tile, full-rate grants
    comp_delay = 5;
    push_job(1);
    start_job(1, c0);
    chk("ready_low_in_run", 32'(ready), 0);
    wait_done(100);
    chk("t1_clr_count", 32'(clr_q.size()), 1);
    if (clr_q.size() > 0) chk("t1_clr_lat", 32'(clr_q[0] - c0), 1);
    chk("t1_switch_lat", 32'(last_sw - c0), 6);
    chk("t1_start_if_lat", 32'(last_si - c0), 7);
    chk("t1_done_lat", 32'(last_done - c0), 14);
`ifdef WPF_PERF_CNT_EN
    chk("perf_stall_before_switch", 32'(stall_at_sw), 5);
    chk("perf_fill_cycles", fill_cycles, 4);
`endif

    // Three tiles, fill overlaps compute; mid-job start must be ignored
    comp_delay = 10;
    overlap = 0;
    s0 = si_cnt;
    d0 = done_cnt;
    push_job(3);
    start_job(3, c0);
    repeat (3) tick();
    start = 1'b1;
    num_tiles = 16'd5;
    tick();
    start = 1'b0;
    wait_done(300);
    chk("t2_start_if_count", 32'(si_cnt - s0), 3);
    chk("t2_done_count", 32'(done_cnt - d0), 1);
    chk("t2_overlap", 32'(overlap), 1);
    if (clr_q.size() > 1) chk("t2_fill_period", 32'(clr_q[1] - clr_q[0]), 5);
    else chk("t2_clr_count", 32'(clr_q.size()), 3);

    // Toggling grants: 8 cycles per tile
    gnt_toggle = 1;
    comp_delay = 30;
    push_job(2);
    start_job(2, c0);
    wait_done(300);
    gnt_toggle = 0;
    if (clr_q.size() > 1) chk("t3_fill_period", 32'(clr_q[1] - clr_q[0]), 8);
    else chk("t3_clr_count", 32'(clr_q.size()), 2);

    // if_ready low with both banks full
    if_ready = 1'b0;
    comp_delay = 4;
    s0 = sw_cnt;
    push_job(3);
    start_job(3, c0);
    repeat (20) tick();
    chk("t4_w_read_blocked", 32'(w_read), 0);
    chk("t4_no_switch", 32'(sw_cnt - s0), 0);
    if_ready = 1'b1;
    tick();
    chk("t4_switch_same_cycle", 32'(switch), 1);
    chk("t4_act_bank", 32'(act_bank), 0);
    tick();
    chk("t4_start_if_next", 32'(start_if), 1);
    wait_done(200);

    // Zero-tile job
    exp_done.push_back(1);
    start_job(0, c0);
    chk("t5_zero_done", 32'(done), 1);
    chk("t5_zero_ready", 32'(ready), 1);
    tick();
    chk("t5_zero_done_once", 32'(done), 0);
    chk("t5_zero_ready_hold", 32'(ready), 1);

    // Reset during tile 2 fill
    comp_delay = 20;
    push_job(3);
    start_job(3, c0);
    n = 0;
    while (!(w_read && w_bank == 1) && n < 100) begin
      tick();
      n++;
    end
    chk("t6_tile2_fill_seen", 32'(w_read && w_bank == 1), 1);
    tick();
    rst = 1'b1;
    tick();
    chk_reset_vals("midrst");
    exp_xfer.delete();
    exp_sw.delete();
    exp_done.delete();
    d0 = done_cnt;
    rst = 1'b0;
    repeat (30) tick();
    chk("t6_no_done_after_reset", 32'(done_cnt - d0), 0);
    chk("t6_idle_ready", 32'(ready), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/w_prefetch_ctrl.md
Name: w_prefetch_ctrl

Overview:
Multi-bank weight prefetch controller for the systolic array. It fetches NUM_TILES weight tiles of ROWS rows each into NBANK weight buffer banks, filling ahead of compute. It hands full banks to the compute side when the input-feature path is ready, and releases each bank when its compute pass completes. It generalises the single ping-pong weight controller to N banks, multi-tile jobs and a row-level request/grant interface.

Parameters:
ROWS, 8, weight rows per tile (systolic array height), >=2
NBANK, 2, number of weight buffer banks, >=2
TILE_W, 16, width of the tile count and tile counters
RW, $clog2(ROWS), row index width (derived)
BW, $clog2(NBANK), bank index width (derived)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  job start pulse; sampled only when ready=1
num_tiles  in  TILE_W  tiles in job; latched on accepted start
w_read  out  1  weight row request
w_gnt  in  1  memory grant; w_read&w_gnt = one row transferred
w_row  out  RW  row index of current transfer
w_bank  out  BW  bank being filled
clr_w  out  1  one-cycle pulse at start of each bank fill
if_ready  in  1  compute/input-feature side idle, level
comp_done  in  1  one-cycle pulse: compute on act_bank finished
switch  out  1  one-cycle pulse: act_bank changes this cycle
act_bank  out  BW  bank owned by compute
start_if  out  1  compute start pulse, one cycle after switch
ready  out  1  idle, can accept start
done  out  1  one-cycle pulse: job fully computed

Behaviour:
- Reset values: w_read=0, w_row=0, w_bank=0, clr_w=0, switch=0, act_bank=0, start_if=0, ready=1, done=0. All counters, bank-full flags and comp_active clear to 0. FSM goes to IDLE.
- All outputs are registered.
- Main FSM:
  - IDLE: ready=1. On start with num_tiles!=0, latch num_tiles and go to RUN. On start with num_tiles==0, pulse done next cycle and stay in IDLE.
  - RUN: ready=0. The fill and launch engines run concurrently.
  - When tiles_done==num_tiles, pulse done for one cycle and return to IDLE.
  - start while ready=0 is ignored.
- Fill engine:
  - Begins a bank fill when tiles_fetched<num_tiles and bank full[wr_bank]=0 and the bank is not act_bank while comp_active=1.
  - In the first fill cycle: clr_w=1, w_read=1, w_row=0, w_bank=wr_bank.
  - w_read stays high until ROWS grants have been received. w_row increments only on w_read&w_gnt.
  - On the grant with w_row==ROWS-1: deassert w_read the next cycle, set full[wr_bank], wr_bank wraps modulo NBANK, tiles_fetched++.
  - The next fill may begin the cycle after, so a full-rate fill is ROWS+1 cycles per tile.
  - w_read never drops mid-tile. Grant gaps only stall w_row.
- Launch engine:
  - Condition: full[rd_bank]=1 and comp_active=0 and if_ready=1.
  - In that cycle: switch=1, act_bank<=rd_bank, full[rd_bank] cleared, comp_active=1, rd_bank wraps, tiles_launched++.
  - start_if=1 in the following cycle.
- On comp_done with comp_active=1: comp_active=0, tiles_done++, act_bank released. comp_done while comp_active=0 is ignored.
- Simultaneous events:
  - comp_done and a launch opportunity in the same cycle: comp_done is applied and the launch occurs next cycle at the earliest.
  - Fill completion and launch of the same bank in the same cycle: impossible, because full is set first and launch needs full=1 already.
  - Bank released and a fill wanting that bank in the same cycle: the fill starts next cycle.
- With NBANK banks, at most NBANK-1 tiles are prefetched while one bank computes.
- Reset mid-operation: abort immediately. All outputs return to reset values and no done pulse is issued.

Optional Feature:
WPF_PERF_CNT_EN
- Defined: adds output ports stall_cycles [31:0] and fill_cycles [31:0], both cleared on accepted start.
  - stall_cycles increments every RUN cycle with if_ready=1, comp_active=0 and full[rd_bank]=0.
  - fill_cycles increments every cycle w_read=1.
  - Both saturate at all-ones and hold their value in IDLE.
- Undefined: the ports and logic are absent. All other behaviour is identical.

Test Plan:
- ROWS=4, NBANK=2, num_tiles=1, w_gnt=1, if_ready=1, comp_done 5 cycles after start_if -> clr_w + w_read for 4 cycles with w_row 0..3 on bank 0; switch with act_bank=0, start_if next cycle; done one cycle after tiles_done reaches 1.
- num_tiles=3, constant if_ready and delayed comp_done -> tile 2 fill on bank 1 overlaps tile 1 compute; act_bank sequence 0,1,0; exactly 3 start_if pulses and 1 done.
- w_gnt toggling 1,0,1,0 -> w_read held high, w_row advances only on grant cycles, 8 cycles per 4-row tile.
- if_ready=0 with both banks full -> w_read stays 0 and no switch; raising if_ready produces switch the same cycle and start_if the next.
- start with num_tiles=0 -> done pulse next cycle, ready stays 1; rst asserted during tile 2 fill -> next cycle all outputs at reset values and no done pulse.
- WPF_PERF_CNT_EN defined, if_ready=1 during the first fill (ROWS=4) -> stall_cycles counts the cycles before the first switch; fill_cycles=4*num_tiles with w_gnt=1.
